lsu_riscv: RTL and testbench

LSU_RISCV -- requirements
Module: lsu_riscv

---
 rtl/lsu_riscv.sv | 181 ++++++++++++++++++
 tb/tb_lsu_riscv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_riscv.sv
// Load/store unit: 2-cycle minimum latency (request + response), single outstanding access.
// Backpressure: holds the memory request stable until data_gnt_i; stalls the core until data_rvalid_i.
module lsu_riscv (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic        lsu_stall_req_o,
   output logic [31:0] lsu_data_o,
   output logic        lsu_misalign_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q;
   logic        we_q;
   logic [2:0]  size_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;

   logic        req_vld;
   logic        stall;
   logic        misalign;
   logic        capture;
   logic        ld_done;
   logic        use_inputs;
   logic [2:0]  req_size;
   logic        req_mis;
   logic [31:0] sel_addr;
   logic [31:0] sel_data;
   logic [2:0]  sel_size;
   logic        sel_we;
   logic [31:0] ld_fmt;

   // Unknown size codes collapse to a plain byte access.
   function automatic logic [2:0] norm_size(input logic [2:0] s);
      case (s)
         LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: return s;
         default:                                  return LDST_B;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] s, input logic [1:0] off);
      case (s)
         LDST_H, LDST_HU: return off[0];
         LDST_W:          return (off != 2'b00);
         default:         return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] s, input logic [1:0] off);
      case (s)
         LDST_H, LDST_HU: return 4'b0011 << {off[1], 1'b0};
         LDST_W:          return 4'b1111;
         default:         return 4'b0001 << off;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] s, input logic [31:0] d);
      case (s)
         LDST_H, LDST_HU: return {2{d[15:0]}};
         LDST_W:          return d;
         default:         return {4{d[7:0]}};
      endcase
   endfunction

   function automatic logic [31:0] load_format(input logic [2:0] s, input logic [1:0] off,
                                               input logic [31:0] rd);
      logic [31:0] shifted;
      logic [15:0] hw;
      logic [7:0]  bt;
      shifted = rd >> {off, 3'b000};
      hw      = off[1] ? rd[31:16] : rd[15:0];
      bt      = shifted[7:0];
      case (s)
         LDST_W:  return rd;
         LDST_H:  return {{16{hw[15]}}, hw};
         LDST_HU: return {16'h0000, hw};
         LDST_BU: return {24'h000000, bt};
         default: return {{24{bt[7]}}, bt};
      endcase
   endfunction

   assign req_size = norm_size(lsu_size_i);
   assign req_mis  = is_misaligned(req_size, lsu_addr_i[1:0]);

   always_comb begin
      state_d    = state_q;
      req_vld    = 1'b0;
      stall      = 1'b0;
      misalign   = 1'b0;
      capture    = 1'b0;
      ld_done    = 1'b0;
      use_inputs = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (lsu_req_i) begin
               if (req_mis) begin
                  misalign = 1'b1;
               end else begin
                  capture    = 1'b1;
                  use_inputs = 1'b1;
                  req_vld    = 1'b1;
                  stall      = 1'b1;
                  state_d    = data_gnt_i ? S_WAIT : S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            req_vld = 1'b1;
            stall   = 1'b1;
            if (data_gnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            stall = !data_rvalid_i;
            if (data_rvalid_i) begin
               state_d = S_IDLE;
               ld_done = !we_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The request cycle drives memory straight from the core; later cycles replay the captured copy.
   assign sel_addr = use_inputs ? lsu_addr_i : addr_q;
   assign sel_data = use_inputs ? lsu_data_i : wdata_q;
   assign sel_size = use_inputs ? req_size   : size_q;
   assign sel_we   = use_inputs ? lsu_we_i   : we_q;

   assign ld_fmt = load_format(size_q, addr_q[1:0], data_rdata_i);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q  <= lsu_addr_i;
            we_q    <= lsu_we_i;
            size_q  <= req_size;
            wdata_q <= lsu_data_i;
         end
         if (ld_done) rdata_q <= ld_fmt;
      end
   end

   // Combinational request paths would otherwise leak core inputs while reset is held.
   assign data_req_o      = arstn_i & req_vld;
   assign data_we_o       = arstn_i & sel_we;
   assign data_be_o       = {4{arstn_i}} & byte_en(sel_size, sel_addr[1:0]);
   assign data_addr_o     = {32{arstn_i}} & {sel_addr[31:2], 2'b00};
   assign data_wdata_o    = {32{arstn_i}} & store_data(sel_size, sel_data);
   assign lsu_stall_req_o = arstn_i & stall;
   assign lsu_misalign_o  = arstn_i & misalign;
   assign lsu_data_o      = {32{arstn_i}} & (ld_done ? ld_fmt : rdata_q);

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for lsu_riscv: inputs change 1ns after the rising edge, outputs sampled 1ns later.
module tb_lsu_riscv;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic        lsu_stall_req_o;
   logic [31:0] lsu_data_o;
   logic        lsu_misalign_o;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   int checks = 0;
   int errors = 0;

   lsu_riscv dut (
      .clk_i(clk_i), .arstn_i(arstn_i),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
      .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
      .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o), .lsu_misalign_o(lsu_misalign_o),
      .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic req, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic gnt, input logic rvalid, input logic [31:0] rdata);
      lsu_req_i     = req;
      lsu_we_i      = we;
      lsu_size_i    = size;
      lsu_addr_i    = addr;
      lsu_data_i    = data;
      data_gnt_i    = gnt;
      data_rvalid_i = rvalid;
      data_rdata_i  = rdata;
      #1;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      // Reset held while the core presents an aligned store: everything must read 0.
      arstn_i = 1'b0;
      drive(1'b1, 1'b1, 3'd2, 32'h0000_0104, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
      tick();
      tick();
      chk("rst_req",      {31'h0, data_req_o},      32'h0);
      chk("rst_we",       {31'h0, data_we_o},       32'h0);
      chk("rst_be",       {28'h0, data_be_o},       32'h0);
      chk("rst_addr",     data_addr_o,              32'h0);
      chk("rst_wdata",    data_wdata_o,             32'h0);
      chk("rst_stall",    {31'h0, lsu_stall_req_o}, 32'h0);
      chk("rst_ldata",    lsu_data_o,               32'h0);
      chk("rst_misalign", {31'h0, lsu_misalign_o},  32'h0);
      idle_in();
      arstn_i = 1'b1;
      tick();
      chk("idle_req",   {31'h0, data_req_o},      32'h0);
      chk("idle_stall", {31'h0, lsu_stall_req_o}, 32'h0);

      // LW 0x100, grant in the request cycle, response next cycle.
      drive(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("lw_req",   {31'h0, data_req_o},      32'h1);
      chk("lw_be",    {28'h0, data_be_o},       32'hF);
      chk("lw_addr",  data_addr_o,              32'h0000_0100);
      chk("lw_we",    {31'h0, data_we_o},       32'h0);
      chk("lw_stall", {31'h0, lsu_stall_req_o}, 32'h1);
      tick();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      chk("lw_wait_req",   {31'h0, data_req_o},      32'h0);
      chk("lw_done_stall", {31'h0, lsu_stall_req_o}, 32'h0);
      chk("lw_data_comb",  lsu_data_o,               32'hDEAD_BEEF);
      tick();
      idle_in();
      chk("lw_data_reg", lsu_data_o, 32'hDEAD_BEEF);

      // LB 0x103 sign-extends byte 3.
      drive(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("lb_be",   {28'h0, data_be_o}, 32'h8);
      chk("lb_addr", data_addr_o,        32'h0000_0100);
      tick();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8012_3456);
      chk("lb_data", lsu_data_o, 32'hFFFF_FF80);
      // LBU back-to-back, issued the cycle right after completion.
      tick();
      drive(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("lbu_req", {31'h0, data_req_o}, 32'h1);
      chk("lbu_be",  {28'h0, data_be_o},  32'h8);
      chk("lbu_hold_prev", lsu_data_o,    32'hFFFF_FF80);
      tick();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8012_3456);
      chk("lbu_data", lsu_data_o, 32'h0000_0080);
      tick();
      idle_in();

      // SH 0x202 with the grant three cycles late; core inputs change after the request cycle.
      drive(1'b1, 1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b0, 32'h0);
      chk("sh_req0",   {31'h0, data_req_o}, 32'h1);
      chk("sh_be0",    {28'h0, data_be_o},  32'hC);
      chk("sh_wdata0", data_wdata_o,        32'hABCD_ABCD);
      chk("sh_we0",    {31'h0, data_we_o},  32'h1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         drive(1'b1, 1'b0, 3'd2, 32'h0000_0FFC, 32'h5555_5555, (i == 3), 1'b1, 32'hFFFF_FFFF);
         chk("sh_req_hold",   {31'h0, data_req_o},      32'h1);
         chk("sh_be_hold",    {28'h0, data_be_o},       32'hC);
         chk("sh_addr_hold",  data_addr_o,              32'h0000_0200);
         chk("sh_wdata_hold", data_wdata_o,             32'hABCD_ABCD);
         chk("sh_stall_hold", {31'h0, lsu_stall_req_o}, 32'h1);
      end
      tick();
      idle_in();
      chk("sh_wait_req",   {31'h0, data_req_o},      32'h0);
      chk("sh_wait_stall", {31'h0, lsu_stall_req_o}, 32'h1);
      tick();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
      chk("sh_done_stall", {31'h0, lsu_stall_req_o}, 32'h0);
      chk("sh_keeps_ldata", lsu_data_o,              32'h0000_0080);
      tick();
      idle_in();
      chk("sh_after_ldata", lsu_data_o, 32'h0000_0080);

      // Misaligned LW 0x101: pulse only, no memory traffic.
      drive(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("mis_pulse", {31'h0, lsu_misalign_o},  32'h1);
      chk("mis_req",   {31'h0, data_req_o},      32'h0);
      chk("mis_stall", {31'h0, lsu_stall_req_o}, 32'h0);
      tick();
      idle_in();
      chk("mis_pulse_end", {31'h0, lsu_misalign_o}, 32'h0);

      // LHU 0x006 selects the upper halfword, zero-extended.
      drive(1'b1, 1'b0, 3'd5, 32'h0000_0006, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("lhu_req", {31'h0, data_req_o}, 32'h1);
      chk("lhu_be",  {28'h0, data_be_o},  32'hC);
      tick();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hF00D_1234);
      chk("lhu_data", lsu_data_o, 32'h0000_F00D);
      // LH 0x004 back-to-back, lower halfword sign-extended.
      tick();
      drive(1'b1, 1'b0, 3'd1, 32'h0000_0004, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("lh_b2b_req", {31'h0, data_req_o}, 32'h1);
      chk("lh_be",      {28'h0, data_be_o},  32'h3);
      tick();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_8001);
      chk("lh_data", lsu_data_o, 32'hFFFF_8001);
      tick();
      idle_in();

      // Undefined size code 3 behaves as a signed byte load; SB replicates the byte.
      drive(1'b1, 1'b0, 3'd3, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("code3_mis", {31'h0, lsu_misalign_o}, 32'h0);
      chk("code3_be",  {28'h0, data_be_o},      32'h2);
      tick();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_7F00);
      chk("code3_data", lsu_data_o, 32'h0000_007F);
      tick();
      drive(1'b1, 1'b1, 3'd0, 32'h0000_0042, 32'h0000_00A5, 1'b1, 1'b0, 32'h0);
      chk("sb_wdata", data_wdata_o,        32'hA5A5_A5A5);
      chk("sb_be",    {28'h0, data_be_o},  32'h4);
      tick();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
      tick();
      idle_in();

      // Reset during WAIT abandons the access; a late response is ignored.
      drive(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      idle_in();
      chk("rw_wait_stall", {31'h0, lsu_stall_req_o}, 32'h1);
      arstn_i = 1'b0;
      #1;
      chk("rw_rst_stall", {31'h0, lsu_stall_req_o}, 32'h0);
      chk("rw_rst_ldata", lsu_data_o,               32'h0);
      chk("rw_rst_addr",  data_addr_o,              32'h0);
      tick();
      arstn_i = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
      chk("rw_late_ldata", lsu_data_o,               32'h0);
      chk("rw_late_stall", {31'h0, lsu_stall_req_o}, 32'h0);
      chk("rw_late_req",   {31'h0, data_req_o},      32'h0);
      tick();
      idle_in();
      chk("rw_after_ldata", lsu_data_o, 32'h0);
      // A fresh request is accepted immediately, proving the FSM sits in IDLE.
      drive(1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("rw_idle_accept", {31'h0, data_req_o}, 32'h1);
      tick();
      idle_in();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
